// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY         = 2'b00;
  localparam logic [XLEN-1:0]   DEFAULT_RESET_PC  = 32'h8000_0000;
  localparam logic [XLEN-1:0]   DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_AR    = 3'd0,
    S_R     = 3'd1,
    S_SEND  = 3'd2,
    S_WAIT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu.sv
// Serial instruction fetch: one AR/R read per instruction, handed to decode
// over valid/ready; next fetch starts only once decode supplies the next PC.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_next,
  input  logic              pc_write_enable,
  output logic [XLEN-1:0]   araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [XLEN-1:0]   rdata,
  input  logic [RESP_W-1:0] rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [XLEN-1:0]   instruction,
  output logic [XLEN-1:0]   pc,
  output logic              ifu_send_valid,
  input  logic              idu_ready,
  output logic              ifu_fault
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pend_v;
  logic [XLEN-1:0] r_instr;
  logic            r_send_valid;
  logic            r_fault;
  logic            r_arvalid;
  logic            r_rready;

  logic            w_presented_done;
  logic            w_load;
  logic [XLEN-1:0] w_load_pc;

  // A newest strobe beats a pending one; a pending PC skips the WAIT cycle.
  assign w_presented_done = ((r_state == S_SEND) || (r_state == S_FAULT)) && idu_ready;
  assign w_load    = ((r_state == S_WAIT) || w_presented_done) && (pc_write_enable || r_pend_v);
  assign w_load_pc = pc_write_enable ? pc_next : r_pend_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_AR;
      r_pc         <= RESET_PC;
      r_pend_pc    <= '0;
      r_pend_v     <= 1'b0;
      r_instr      <= '0;
      r_send_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
    end else if (w_load) begin
      r_pc     <= w_load_pc;
      r_pend_v <= 1'b0;
      if (is_misaligned(w_load_pc)) begin
        r_state      <= S_FAULT;
        r_instr      <= NOP_INSTR;
        r_fault      <= 1'b1;
        r_send_valid <= 1'b1;
      end else begin
        r_state      <= S_AR;
        r_arvalid    <= 1'b1;
        r_send_valid <= 1'b0;
      end
    end else begin
      if (pc_write_enable) begin
        r_pend_pc <= pc_next;
        r_pend_v  <= 1'b1;
      end
      case (r_state)
        S_AR: begin
          // arvalid low in AR only right after reset: raise it, or fault on a bad RESET_PC.
          if (!r_arvalid) begin
            if (is_misaligned(r_pc)) begin
              r_state      <= S_FAULT;
              r_instr      <= NOP_INSTR;
              r_fault      <= 1'b1;
              r_send_valid <= 1'b1;
            end else begin
              r_arvalid <= 1'b1;
            end
          end else if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (rvalid) begin
            r_rready     <= 1'b0;
            r_instr      <= (rresp == RESP_OKAY) ? rdata : NOP_INSTR;
            r_fault      <= (rresp != RESP_OKAY);
            r_send_valid <= 1'b1;
            r_state      <= S_SEND;
          end
        end
        S_SEND, S_FAULT: begin
          if (idu_ready) begin
            r_send_valid <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state <= S_WAIT;
        end
        default: r_state <= S_AR;
      endcase
    end
  end

  assign araddr         = r_pc;
  assign pc             = r_pc;
  assign arvalid        = r_arvalid;
  assign rready         = r_rready;
  assign instruction    = r_instr;
  assign ifu_send_valid = r_send_valid;
  assign ifu_fault      = r_fault;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: fetch, stalls, bus faults, misaligned PCs, redirects and reset.
module tb_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_write_enable;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        ifu_send_valid;
  logic        idu_ready;
  logic        ifu_fault;

  int errors = 0;
  int checks = 0;
  int ar_hs  = 0;
  int r_hs   = 0;

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .pc_next        (pc_next),
    .pc_write_enable(pc_write_enable),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .instruction    (instruction),
    .pc             (pc),
    .ifu_send_valid (ifu_send_valid),
    .idu_ready      (idu_ready),
    .ifu_fault      (ifu_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
    if (!rst && rvalid && rready)   r_hs  <= r_hs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one AR+R exchange with zero wait states starting from arvalid high.
  task automatic drive_fetch(input logic [31:0] data, input logic [1:0] resp);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = data;
    rresp   = resp;
    step();
    rvalid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%b exp=0", rready); end
    checks++; if (ifu_send_valid !== 1'b0) begin errors++; $display("FAIL reset_send_valid got=%b exp=0", ifu_send_valid); end
    checks++; if (ifu_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", ifu_fault); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=00000000", instruction); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=80000000", pc); end
    rst = 1'b0;
    step();
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL post_reset_arvalid got=%b exp=1", arvalid); end
    checks++; if (araddr !== 32'h8000_0000) begin errors++; $display("FAIL post_reset_araddr got=%h exp=80000000", araddr); end
  endtask

  task automatic test_basic_fetch();
    arready = 1'b1;
    step();
    arready = 1'b0;
    checks++; if (rready !== 1'b1 || arvalid !== 1'b0) begin errors++; $display("FAIL basic_r_phase got rready=%b arvalid=%b exp 1/0", rready, arvalid); end
    rvalid = 1'b1; rdata = 32'h0000_0297; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    checks++; if (ifu_send_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", ifu_send_valid); end
    checks++; if (instruction !== 32'h0000_0297) begin errors++; $display("FAIL basic_instr got=%h exp=00000297", instruction); end
    checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL basic_pc got=%h exp=80000000", pc); end
    checks++; if (ifu_fault !== 1'b0) begin errors++; $display("FAIL basic_fault got=%b exp=0", ifu_fault); end
  endtask

  task automatic test_stall();
    idu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ifu_send_valid !== 1'b1 || instruction !== 32'h0000_0297 || pc !== 32'h8000_0000 || arvalid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got valid=%b instr=%h pc=%h arvalid=%b exp 1/00000297/80000000/0",
                 i, ifu_send_valid, instruction, pc, arvalid);
      end
    end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
    checks++; if (ifu_send_valid !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL stall_accept got valid=%b arvalid=%b exp 0/0", ifu_send_valid, arvalid); end
    step();
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL wait_idle_arvalid got=%b exp=0", arvalid); end
  endtask

  task automatic test_arready_delay();
    int ar0, r0;
    ar0 = ar_hs; r0 = r_hs;
    pc_write_enable = 1'b1; pc_next = 32'h8000_0004;
    step();
    pc_write_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_0004) begin
        errors++;
        $display("FAIL ardelay_hold cyc=%0d got arvalid=%b araddr=%h exp 1/80000004", i, arvalid, araddr);
      end
      if (i == 3) arready = 1'b1;
      step();
    end
    arready = 1'b0;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL ardelay_r got arvalid=%b rready=%b exp 0/1", arvalid, rready); end
    rvalid = 1'b1; rdata = 32'h0000_0513; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    step();
    checks++; if (ar_hs - ar0 !== 1) begin errors++; $display("FAIL ardelay_ar_hs got=%0d exp=1", ar_hs - ar0); end
    checks++; if (r_hs - r0 !== 1) begin errors++; $display("FAIL ardelay_r_hs got=%0d exp=1", r_hs - r0); end
    checks++; if (ifu_send_valid !== 1'b1 || instruction !== 32'h0000_0513 || pc !== 32'h8000_0004) begin
      errors++; $display("FAIL ardelay_send got valid=%b instr=%h pc=%h exp 1/00000513/80000004", ifu_send_valid, instruction, pc); end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
  endtask

  task automatic test_resp_error();
    pc_write_enable = 1'b1; pc_next = 32'h8000_0008;
    step();
    pc_write_enable = 1'b0;
    drive_fetch(32'hDEAD_BEEF, 2'b10);
    checks++; if (ifu_send_valid !== 1'b1 || ifu_fault !== 1'b1) begin errors++; $display("FAIL resperr_flags got valid=%b fault=%b exp 1/1", ifu_send_valid, ifu_fault); end
    checks++; if (instruction !== 32'h0000_0013) begin errors++; $display("FAIL resperr_instr got=%h exp=00000013", instruction); end
    checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL resperr_pc got=%h exp=80000008", pc); end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    int ar0;
    ar0 = ar_hs;
    pc_write_enable = 1'b1; pc_next = 32'h8000_0006;
    step();
    pc_write_enable = 1'b0;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL misalign_arvalid got=%b exp=0", arvalid); end
    checks++; if (ifu_send_valid !== 1'b1 || ifu_fault !== 1'b1 || instruction !== 32'h0000_0013) begin
      errors++; $display("FAIL misalign_present got valid=%b fault=%b instr=%h exp 1/1/00000013", ifu_send_valid, ifu_fault, instruction); end
    checks++; if (pc !== 32'h8000_0006) begin errors++; $display("FAIL misalign_pc got=%h exp=80000006", pc); end
    step();
    checks++; if (arvalid !== 1'b0 || ifu_send_valid !== 1'b1) begin errors++; $display("FAIL misalign_hold got arvalid=%b valid=%b exp 0/1", arvalid, ifu_send_valid); end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
    checks++; if (ifu_send_valid !== 1'b0) begin errors++; $display("FAIL misalign_accept got=%b exp=0", ifu_send_valid); end
    pc_write_enable = 1'b1; pc_next = 32'h8000_0008;
    step();
    pc_write_enable = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0008) begin errors++; $display("FAIL misalign_resume got arvalid=%b araddr=%h exp 1/80000008", arvalid, araddr); end
    checks++; if (ar_hs !== ar0) begin errors++; $display("FAIL misalign_no_bus got=%0d exp=%0d", ar_hs, ar0); end
    drive_fetch(32'h00A0_0093, 2'b00);
    checks++; if (ifu_fault !== 1'b0 || instruction !== 32'h00A0_0093) begin errors++; $display("FAIL misalign_refetch got fault=%b instr=%h exp 0/00a00093", ifu_fault, instruction); end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
  endtask

  task automatic test_early_redirect();
    pc_write_enable = 1'b1; pc_next = 32'h8000_000C;
    step();
    pc_write_enable = 1'b0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    pc_write_enable = 1'b1; pc_next = 32'h8000_0010;
    step();
    pc_write_enable = 1'b0;
    checks++; if (rready !== 1'b1 || ifu_send_valid !== 1'b0) begin errors++; $display("FAIL redirect_inflight got rready=%b valid=%b exp 1/0", rready, ifu_send_valid); end
    rvalid = 1'b1; rdata = 32'h1111_1111; rresp = 2'b00;
    step();
    rvalid = 1'b0;
    checks++; if (ifu_send_valid !== 1'b1 || pc !== 32'h8000_000C || instruction !== 32'h1111_1111) begin
      errors++; $display("FAIL redirect_send got valid=%b pc=%h instr=%h exp 1/8000000c/11111111", ifu_send_valid, pc, instruction); end
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010 || ifu_send_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_nostall got arvalid=%b araddr=%h valid=%b exp 1/80000010/0", arvalid, araddr, ifu_send_valid); end
  endtask

  task automatic test_last_wins();
    pc_write_enable = 1'b1; pc_next = 32'h8000_0020;
    step();
    pc_next = 32'h8000_0024;
    step();
    pc_write_enable = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010) begin errors++; $display("FAIL lastwins_stable got arvalid=%b araddr=%h exp 1/80000010", arvalid, araddr); end
    drive_fetch(32'h2222_2222, 2'b00);
    idu_ready = 1'b1;
    step();
    idu_ready = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0024) begin errors++; $display("FAIL lastwins_addr got arvalid=%b araddr=%h exp 1/80000024", arvalid, araddr); end
  endtask

  task automatic test_same_cycle();
    drive_fetch(32'h3333_3333, 2'b00);
    idu_ready = 1'b1; pc_write_enable = 1'b1; pc_next = 32'h8000_0030;
    step();
    idu_ready = 1'b0; pc_write_enable = 1'b0;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0030 || ifu_send_valid !== 1'b0) begin
      errors++; $display("FAIL samecycle got arvalid=%b araddr=%h valid=%b exp 1/80000030/0", arvalid, araddr, ifu_send_valid); end
  endtask

  task automatic test_reset_mid();
    arready = 1'b1;
    step();
    arready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL rstmid_clear got arvalid=%b rready=%b exp 0/0", arvalid, rready); end
    rvalid = 1'b1; rdata = 32'h4444_4444; rresp = 2'b00;
    step();
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0000) begin errors++; $display("FAIL rstmid_ar got arvalid=%b araddr=%h exp 1/80000000", arvalid, araddr); end
    step();
    rvalid = 1'b0;
    checks++; if (ifu_send_valid !== 1'b0 || arvalid !== 1'b1) begin errors++; $display("FAIL rstmid_late_r got valid=%b arvalid=%b exp 0/1", ifu_send_valid, arvalid); end
  endtask

  initial begin
    rst = 1'b1; pc_next = '0; pc_write_enable = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0; idu_ready = 1'b0;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_arready_delay();
    test_resp_error();
    test_misaligned();
    test_early_redirect();
    test_last_wins();
    test_same_cycle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifu.md
Name: ifu

Overview:
- Instruction-fetch stage; sits directly upstream of the decode stage.
- Holds the architectural PC and issues one 32-bit instruction read per instruction over an AXI4-Lite-style read channel (AR/R).
- Presents {instruction, pc} to decode with a valid/ready handshake.
- Fetches the next instruction only after decode returns the next PC via pc_write_enable/pc_next. This gives a strictly serial, one-instruction-in-flight fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented to decode when a fetch faults.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pc_next  in  32  next PC computed by decode
- pc_write_enable  in  1  one-cycle strobe: load pc_next, start next fetch
- araddr  out  32  read address (= current pc)
- arvalid  out  1  read address valid
- arready  in  1  read address accepted
- rdata  in  32  read data
- rresp  in  2  read response; 2'b00 = OKAY
- rvalid  in  1  read data valid
- rready  out  1  ready for read data
- instruction  out  32  fetched instruction to decode
- pc  out  32  PC of the presented instruction
- ifu_send_valid  out  1  instruction/pc valid to decode
- idu_ready  in  1  decode accepts instruction this cycle
- ifu_fault  out  1  presented instruction came from a faulting fetch (misaligned or rresp≠OKAY); qualified by ifu_send_valid

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc_r = RESET_PC; state = AR; instruction = 0; ifu_send_valid = 0; ifu_fault = 0; arvalid = 0; rready = 0; pend_v = 0.
  - arvalid rises in the first cycle after rst deasserts.
- State machine, one transition per clock:
  - AR: arvalid=1, araddr=pc_r. On arvalid&&arready go to R. arvalid and araddr stay stable until accepted; no combinational dependency on arready.
  - R: rready=1. On rvalid, latch instruction (rdata if rresp==OKAY, else NOP_INSTR) and ifu_fault=(rresp≠OKAY), then go to SEND. rvalid in AR is ignored.
  - SEND: ifu_send_valid=1; instruction, pc and ifu_fault are held stable. On idu_ready go to WAIT; ifu_send_valid drops the next cycle.
  - WAIT: idle, waiting for the next PC. On pc_write_enable (or pend_v set), pc_r ← pc_next (or pend_pc), clear pend_v, then go to AR; or go to FAULT if the new PC is misaligned.
  - FAULT: no bus request. Present instruction=NOP_INSTR, ifu_fault=1, ifu_send_valid=1. On idu_ready go to WAIT.
- Misaligned PC: pc[1:0]≠0 on load (including a misaligned RESET_PC) goes to FAULT instead of AR.
- Early redirect: pc_write_enable arriving in AR, R or SEND is captured into pend_pc/pend_v. An in-flight bus transaction is never abandoned. pend_v is consumed on entry to WAIT, giving a zero-cycle stay in WAIT.
- Repeated strobes: a second pc_write_enable while pend_v=1 overwrites pend_pc (last wins).
- pc_write_enable in the same cycle as the SEND→WAIT transition is treated as arriving in WAIT (direct load).
- pc output = pc_r, stable from AR through SEND.
- Latency: pc_write_enable at cycle T → arvalid at T+1 → best-case (arready at T+1, rvalid at T+2) ifu_send_valid at T+3.
- Widths: all 32-bit. PC arithmetic is not performed here; the +4 increment is done by decode.
- Reset mid-transaction: the FSM returns to AR at RESET_PC. A late rvalid for the old request is ignored because it arrives in AR, so the bus must not return data before the new AR handshake.

Decomposition:
- Shared package ifu_pkg holds:
  - state enum {AR, R, SEND, WAIT, FAULT}
  - RESP_OKAY = 2'b00
  - default RESET_PC and NOP_INSTR constants
- No sub-module: the FSM, pending-PC register and output registers are kept in one module.

Test Plan:
- Reset, then arready=1 immediately and rvalid one cycle later with rdata=32'h0000_0297 → araddr=32'h8000_0000; ifu_send_valid=1 with instruction=32'h0000_0297, pc=32'h8000_0000, ifu_fault=0.
- Hold idu_ready=0 for 5 cycles in SEND → instruction/pc/ifu_send_valid unchanged; no new arvalid.
- After accept, pulse pc_write_enable with pc_next=32'h8000_0004; delay arready by 3 cycles → arvalid held high 4 cycles with araddr=32'h8000_0004; exactly one R handshake.
- Fetch returns rresp=2'b10 → instruction=32'h0000_0013, ifu_fault=1.
- pc_next=32'h8000_0006 → no arvalid; FAULT presents ifu_fault=1, instruction=NOP_INSTR; a following pc_write_enable with pc_next=32'h8000_0008 resumes fetching.
- pc_write_enable with pc_next=32'h8000_0010 pulsed during R → the current fetch completes; after accept, the next araddr is 32'h8000_0010 with no WAIT stall. Assert rst during R → arvalid with araddr=RESET_PC the cycle after rst drops.
